hazard_fwd_ctrl: RTL and testbench

//  Producer of the select lines for the datapath priority muxes (s1 > s2 > s3 > default).

---
 rtl/hazard_fwd_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding-select and stall controller for a 5-stage pipeline.
// Tracks EX/MEM/WB destinations and drives one-hot operand mux selects plus load-use/memory-wait stalls.
module hazard_fwd_ctrl #(
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16,
    parameter int FWD_WB = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_addr,
    input  logic             id_is_load,
    input  logic             id_flush,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             fwd_rs_ex,
    output logic             fwd_rs_mem,
    output logic             fwd_rs_wb,
    output logic             fwd_rt_ex,
    output logic             fwd_rt_mem,
    output logic             fwd_rt_wb,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    state_t cur_state, nxt_state;

    logic             ex_valid, ex_wr_en, ex_is_load;
    logic [REG_W-1:0] ex_addr;
    logic             mem_valid, mem_wr_en;
    logic [REG_W-1:0] mem_addr;
    logic             wb_valid, wb_wr_en;
    logic [REG_W-1:0] wb_addr;

    logic load_use, stall_int;
    logic rs_ex_m, rs_mem_m, rs_wb_m, rt_ex_m, rt_mem_m, rt_wb_m;

    function automatic logic match(input logic v, input logic w,
                                   input logic [REG_W-1:0] a, input logic [REG_W-1:0] r);
        return v & w & (a == r) & (r != '0);
    endfunction

    always_comb begin
        rs_ex_m  = match(ex_valid,  ex_wr_en,  ex_addr,  id_rs);
        rs_mem_m = match(mem_valid, mem_wr_en, mem_addr, id_rs);
        rs_wb_m  = match(wb_valid,  wb_wr_en,  wb_addr,  id_rs);
        rt_ex_m  = match(ex_valid,  ex_wr_en,  ex_addr,  id_rt);
        rt_mem_m = match(mem_valid, mem_wr_en, mem_addr, id_rt);
        rt_wb_m  = match(wb_valid,  wb_wr_en,  wb_addr,  id_rt);
    end

    // Youngest producer wins; a load in EX blocks fall-through to older stages.
    always_comb begin
        fwd_rs_ex  = id_valid & id_uses_rs & rs_ex_m & ~ex_is_load;
        fwd_rs_mem = id_valid & id_uses_rs & rs_mem_m & ~rs_ex_m;
        fwd_rs_wb  = id_valid & id_uses_rs & rs_wb_m & ~rs_ex_m & ~rs_mem_m & (FWD_WB != 0);
        fwd_rt_ex  = id_valid & id_uses_rt & rt_ex_m & ~ex_is_load;
        fwd_rt_mem = id_valid & id_uses_rt & rt_mem_m & ~rt_ex_m;
        fwd_rt_wb  = id_valid & id_uses_rt & rt_wb_m & ~rt_ex_m & ~rt_mem_m & (FWD_WB != 0);
    end

    always_comb begin
        load_use = id_valid & ~id_flush & ex_valid & ex_is_load & ex_wr_en & (ex_addr != '0)
                 & ((id_uses_rs & (ex_addr == id_rs)) | (id_uses_rt & (ex_addr == id_rt)));
        stall_int = ~mem_ready | load_use;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_state <= RUN;
        else     cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = RUN;
        if (!mem_ready)    nxt_state = MEMWAIT;
        else if (load_use) nxt_state = LDSTALL;
    end

    // Stall outputs are masked by rst so everything reads 0 while reset is held.
    always_comb begin
        state     = cur_state;
        freeze    = ~rst & ~mem_ready;
        stall_id  = ~rst & stall_int;
        bubble_ex = ~rst & mem_ready & load_use;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_wr_en   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_addr    <= '0;
            mem_valid  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            wb_valid   <= 1'b0;
            wb_wr_en   <= 1'b0;
            wb_addr    <= '0;
        end else if (mem_ready) begin
            mem_valid <= ex_valid;
            mem_wr_en <= ex_wr_en;
            mem_addr  <= ex_addr;
            wb_valid  <= mem_valid;
            wb_wr_en  <= mem_wr_en;
            wb_addr   <= mem_addr;
            if (load_use) begin
                ex_valid   <= 1'b0;
                ex_wr_en   <= 1'b0;
                ex_is_load <= 1'b0;
                ex_addr    <= '0;
            end else begin
                ex_valid   <= id_valid & ~id_flush;
                ex_wr_en   <= id_wr_en;
                ex_is_load <= id_is_load;
                ex_addr    <= id_wr_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         stall_count <= '0;
        else if (cnt_clr)                stall_count <= '0;
        else if (stall_int && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios plus random traffic
// compared against a stage-list reference model.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_flush;
    logic [4:0] id_rs, id_rt, id_wr_addr;
    logic       mem_ready, cnt_clr;
    logic       fwd_rs_ex, fwd_rs_mem, fwd_rs_wb, fwd_rt_ex, fwd_rt_mem, fwd_rt_wb;
    logic       stall_id, bubble_ex, freeze;
    logic [1:0] state;
    logic [15:0] stall_count;

    int passes = 0;
    int total  = 0;

    // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
    bit       m_v[3], m_w[3], m_l[3];
    bit [4:0] m_a[3];
    int       m_state;
    int       m_cnt;

    hazard_fwd_ctrl #(.REG_W(5), .CNT_W(16), .FWD_WB(1)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .id_flush(id_flush), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .fwd_rs_ex(fwd_rs_ex), .fwd_rs_mem(fwd_rs_mem), .fwd_rs_wb(fwd_rs_wb),
        .fwd_rt_ex(fwd_rt_ex), .fwd_rt_mem(fwd_rt_mem), .fwd_rt_wb(fwd_rt_wb),
        .stall_id(stall_id), .bubble_ex(bubble_ex), .freeze(freeze),
        .state(state), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int youngest(input bit [4:0] r);
        for (int s = 0; s < 3; s++)
            if (m_v[s] && m_w[s] && m_a[s] == r && r != 0) return s;
        return -1;
    endfunction

    function automatic bit model_lu();
        return id_valid && !id_flush && m_v[0] && m_l[0] && m_w[0] && m_a[0] != 0 &&
               ((id_uses_rs && m_a[0] == id_rs) || (id_uses_rt && m_a[0] == id_rt));
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_v[s] = 0; m_w[s] = 0; m_l[s] = 0; m_a[s] = 0;
        end
        m_state = 0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        int  ys, yt;
        bit  lu, rsu, rtu;
        ys  = youngest(id_rs);
        yt  = youngest(id_rt);
        rsu = id_valid && id_uses_rs && !rst;
        rtu = id_valid && id_uses_rt && !rst;
        lu  = model_lu() && !rst;
        chk("fwd_rs_ex",  fwd_rs_ex,  rsu && ys == 0 && !m_l[0]);
        chk("fwd_rs_mem", fwd_rs_mem, rsu && ys == 1);
        chk("fwd_rs_wb",  fwd_rs_wb,  rsu && ys == 2);
        chk("fwd_rt_ex",  fwd_rt_ex,  rtu && yt == 0 && !m_l[0]);
        chk("fwd_rt_mem", fwd_rt_mem, rtu && yt == 1);
        chk("fwd_rt_wb",  fwd_rt_wb,  rtu && yt == 2);
        chk("freeze",     freeze,     !rst && !mem_ready);
        chk("stall_id",   stall_id,   !rst && (!mem_ready || lu));
        chk("bubble_ex",  bubble_ex,  !rst && mem_ready && lu);
        chk("state",      state,      m_state);
        chk("stall_count", stall_count, m_cnt);
    endtask

    task automatic model_step();
        bit lu;
        lu = model_lu();
        if (cnt_clr) m_cnt = 0;
        else if ((!mem_ready || lu) && m_cnt < 16'hFFFF) m_cnt++;
        m_state = !mem_ready ? 2 : (lu ? 1 : 0);
        if (mem_ready) begin
            for (int s = 2; s > 0; s--) begin
                m_v[s] = m_v[s-1]; m_w[s] = m_w[s-1]; m_l[s] = m_l[s-1]; m_a[s] = m_a[s-1];
            end
            if (lu) begin
                m_v[0] = 0; m_w[0] = 0; m_l[0] = 0; m_a[0] = 0;
            end else begin
                m_v[0] = id_valid && !id_flush; m_w[0] = id_wr_en;
                m_l[0] = id_is_load;            m_a[0] = id_wr_addr;
            end
        end
    endtask

    // Inputs are applied while clk is low; outputs are checked before the rising edge.
    task automatic cycle(input bit do_chk);
        #2;
        if (do_chk) check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit [4:0] rs, input bit urs, input bit [4:0] rt,
                         input bit urt, input bit we, input bit [4:0] wa, input bit ld,
                         input bit fl, input bit mr);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_wr_en = we; id_wr_addr = wa; id_is_load = ld; id_flush = fl; mem_ready = mr;
    endtask

    task automatic nop_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1);
    endtask

    initial begin
        cnt_clr = 0;
        rst = 1;
        drive(1, 3, 1, 3, 1, 1, 3, 0, 0, 0);
        model_reset();
        @(negedge clk);
        #2 check_outputs();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) nop_cycle();

        // ADD r3 into EX, then read rs=r3
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 1); cycle(1);
        drive(1, 3, 1, 7, 1, 0, 0, 0, 0, 1); cycle(1);
        // ADD r3, SUB r3, then read rt=r3: EX wins
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 1); cycle(1);
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 1); cycle(1);
        drive(1, 1, 1, 3, 1, 0, 0, 0, 0, 1); cycle(1);
        // LW r5 then read rs=r5: one stall, then MEM forward
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 1); cycle(1);
        drive(1, 5, 1, 0, 0, 1, 6, 0, 0, 1); cycle(1);
        cycle(1);
        nop_cycle();
        // Memory wait for three cycles, then resume
        drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 1); cycle(1);
        drive(1, 9, 1, 9, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1);
        mem_ready = 1; cycle(1);
        nop_cycle();
        // Writes to r0, reads of r0, LW r0
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 1); cycle(1);
        end
        drive(1, 0, 1, 0, 1, 1, 0, 1, 0, 1); cycle(1);
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 1); cycle(1);
        // Flush beats load-use
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 1); cycle(1);
        drive(1, 4, 1, 4, 1, 1, 4, 0, 1, 1); cycle(1);
        nop_cycle();

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0);
            cnt_clr = $urandom_range(0, 31) == 0;
            cycle(1);
        end
        cnt_clr = 0;

        // Saturation of stall_count
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65600; i++) cycle(0);
        cycle(1);
        cycle(1);
        cnt_clr = 1; cycle(1);
        cnt_clr = 0; nop_cycle();

        // Reset asserted during LDSTALL
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 1); cycle(1);
        drive(1, 5, 1, 0, 0, 1, 6, 0, 0, 1); cycle(1);
        chk("state_ldstall", state, 2'd1);
        drive(1, 5, 1, 5, 1, 1, 6, 0, 0, 0);
        #2 rst = 1;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst = 0;
        nop_cycle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
